flp_round_reg: RTL and testbench

Registered round-to-nearest-even stage for the floating-point datapath. It takes a normalized significand with its hidden bit and RSWIDTH extra low-order rounding bits, and rounds it to SWIDTH+1 bits. It reports the exponent adjustment needed when rounding carries out of the significand. It sits after normalization in the FP32 add/mul pipelines, with a one-cycle latency.

---
 rtl/flp_pkg.sv | 12 +
 rtl/flp_round_core.sv | 42 ++++
 rtl/flp_round_reg.sv | 61 ++++++
 tb/tb_flp_round_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// Shared FP32 datapath constants and derived widths for the rounding stage.
package flp_pkg;

  localparam int unsigned FP32_EWIDTH  = 8;
  localparam int unsigned FP32_SWIDTH  = 23;
  localparam int unsigned FP32_RSWIDTH = 2;

  localparam int unsigned FP32_IN_W  = FP32_SWIDTH + 1 + FP32_RSWIDTH;
  localparam int unsigned FP32_OUT_W = FP32_SWIDTH + 1;
  localparam int unsigned FP32_EXD_W = FP32_EWIDTH + 2;

endpackage

// File: rtl/flp_round_core.sv
// Combinational round-half-to-even of a normalized significand with extra low-order bits.
module flp_round_core
  import flp_pkg::*;
#(
  parameter int unsigned EWIDTH  = FP32_EWIDTH,
  parameter int unsigned SWIDTH  = FP32_SWIDTH,
  parameter int unsigned RSWIDTH = FP32_RSWIDTH
) (
  input  logic [SWIDTH+RSWIDTH:0] i_sg,
  output logic [SWIDTH:0]         o_sg,
  output logic [EWIDTH+1:0]       o_exd
);

  logic [SWIDTH:0]   m;
  logic              g;
  logic              s;
  logic              roundup;
  logic [SWIDTH+1:0] sum;

  assign m = i_sg[SWIDTH+RSWIDTH:RSWIDTH];
  assign g = i_sg[RSWIDTH-1];

  if (RSWIDTH > 1) begin : g_sticky
    assign s = |i_sg[RSWIDTH-2:0];
  end else begin : g_no_sticky
    assign s = 1'b0;
  end

  // Ties (g set, nothing below) round up only when m is odd.
  assign roundup = g & (s | m[0]);
  assign sum     = {1'b0, m} + {{(SWIDTH + 1){1'b0}}, roundup};

  always_comb begin
    o_sg  = sum[SWIDTH:0];
    o_exd = '0;
    if (sum[SWIDTH+1]) begin
      o_sg  = sum[SWIDTH+1:1];
      o_exd = {{(EWIDTH + 1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/flp_round_reg.sv
// Registered rounding stage: one-cycle latency, outputs hold while no valid sample arrives.
module flp_round_reg
  import flp_pkg::*;
#(
  parameter int unsigned EWIDTH  = FP32_EWIDTH,
  parameter int unsigned SWIDTH  = FP32_SWIDTH,
  parameter int unsigned RSWIDTH = FP32_RSWIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [SWIDTH+RSWIDTH:0] i_sg,
  output logic                    o_vld,
  output logic [SWIDTH:0]         o_sg,
  output logic [EWIDTH+1:0]       o_exd
);

  logic [SWIDTH:0]   core_sg;
  logic [EWIDTH+1:0] core_exd;

  logic              vld_d,  vld_q;
  logic [SWIDTH:0]   sg_d,   sg_q;
  logic [EWIDTH+1:0] exd_d,  exd_q;

  flp_round_core #(
    .EWIDTH  (EWIDTH),
    .SWIDTH  (SWIDTH),
    .RSWIDTH (RSWIDTH)
  ) u_core (
    .i_sg  (i_sg),
    .o_sg  (core_sg),
    .o_exd (core_exd)
  );

  always_comb begin
    vld_d = i_vld;
    sg_d  = sg_q;
    exd_d = exd_q;
    if (i_vld) begin
      sg_d  = core_sg;
      exd_d = core_exd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      sg_q  <= '0;
      exd_q <= '0;
    end else begin
      vld_q <= vld_d;
      sg_q  <= sg_d;
      exd_q <= exd_d;
    end
  end

  assign o_vld = vld_q;
  assign o_sg  = sg_q;
  assign o_exd = exd_q;

endmodule

// File: tb/tb_flp_round_reg.sv
// Directed and random checks of the registered FP32 round-to-nearest-even stage.
module tb_flp_round_reg;

  logic        clk;
  logic        rst;
  logic        i_vld;
  logic [25:0] i_sg;
  logic        o_vld;
  logic [23:0] o_sg;
  logic [9:0]  o_exd;

  int errors;
  int checks;

  logic [23:0] exp_sg;
  logic [9:0]  exp_exd;
  logic [23:0] m_sg;
  logic [9:0]  m_exd;

  flp_round_reg dut (
    .clk   (clk),
    .rst   (rst),
    .i_vld (i_vld),
    .i_sg  (i_sg),
    .o_vld (o_vld),
    .o_sg  (o_sg),
    .o_exd (o_exd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: integer quotient/remainder by 4, carry detected as overflow past 2^24.
  function automatic void ref_round(input logic [25:0] x, output logic [23:0] sg,
                                    output logic [9:0] exd);
    logic [31:0] q;
    logic [31:0] rem;
    q   = {6'd0, x} / 4;
    rem = {6'd0, x} % 4;
    if (rem > 2 || (rem == 2 && q % 2 == 1)) q = q + 1;
    if (q == 32'h0100_0000) begin
      sg  = 24'h800000;
      exd = 10'd1;
    end else begin
      sg  = q[23:0];
      exd = 10'd0;
    end
  endfunction

  // Drive one sample at the falling edge, then sample outputs 1 ns after the next rising edge.
  task automatic step(input logic vld, input logic [25:0] sg);
    @(negedge clk);
    i_vld = vld;
    i_sg  = sg;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string tag, input logic [25:0] sg, input logic [23:0] esg,
                     input logic [9:0] eexd);
    step(1'b1, sg);
    chk({tag, "_vld"}, {31'd0, o_vld}, 32'd1);
    chk({tag, "_sg"}, {8'd0, o_sg}, {8'd0, esg});
    chk({tag, "_exd"}, {22'd0, o_exd}, {22'd0, eexd});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    i_vld  = 1'b0;
    i_sg   = '0;
    #2;
    chk("rst_vld", {31'd0, o_vld}, 32'd0);
    chk("rst_sg", {8'd0, o_sg}, 32'd0);
    chk("rst_exd", {22'd0, o_exd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vec("zero", 26'h0000000, 24'h000000, 10'd0);
    vec("below_half", 26'h0000001, 24'h000000, 10'd0);
    vec("above_half", 26'h0000003, 24'h000001, 10'd0);
    vec("exact", 26'h0000004, 24'h000001, 10'd0);
    vec("tie_even0", 26'h0000002, 24'h000000, 10'd0);
    vec("tie_odd1", 26'h0000006, 24'h000002, 10'd0);
    vec("above_odd1", 26'h0000007, 24'h000002, 10'd0);
    vec("carry_all1", 26'h3FFFFFF, 24'h800000, 10'd1);
    vec("carry_tie", 26'h3FFFFFE, 24'h800000, 10'd1);
    vec("max_no_carry", 26'h3FFFFFD, 24'hFFFFFF, 10'd0);
    vec("tie_even_hi", 26'h2AAAAAA, 24'hAAAAAA, 10'd0);

    // Reset mid-stream clears outputs at once and discards a sample presented during reset.
    vec("pre_rst", 26'h3FFFFFF, 24'h800000, 10'd1);
    @(negedge clk);
    i_vld = 1'b1;
    i_sg  = 26'h0000007;
    rst   = 1'b1;
    #1;
    chk("async_rst_vld", {31'd0, o_vld}, 32'd0);
    chk("async_rst_sg", {8'd0, o_sg}, 32'd0);
    chk("async_rst_exd", {22'd0, o_exd}, 32'd0);
    @(posedge clk);
    #1;
    chk("in_rst_sg", {8'd0, o_sg}, 32'd0);
    chk("in_rst_vld", {31'd0, o_vld}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    vec("post_rst", 26'h0000006, 24'h000002, 10'd0);

    // Streaming with gaps: o_vld follows i_vld, data holds while i_vld is low.
    exp_sg  = 24'h000002;
    exp_exd = 10'd0;
    for (int i = 0; i < 40; i++) begin
      logic        v;
      logic [25:0] x;
      v = (i % 3 == 1) ? 1'b0 : ((i % 5 == 4) ? 1'b0 : 1'b1);
      x = $urandom() & 32'h03FF_FFFF;
      if (i % 8 == 7) x = 26'h3FFFFFC | (x & 26'h3);
      step(v, x);
      if (v) begin
        ref_round(x, m_sg, m_exd);
        exp_sg  = m_sg;
        exp_exd = m_exd;
      end
      chk("stream_vld", {31'd0, o_vld}, {31'd0, v});
      chk("stream_sg", {8'd0, o_sg}, {8'd0, exp_sg});
      chk("stream_exd", {22'd0, o_exd}, {22'd0, exp_exd});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
